// File: rtl/strip_block_reorder.sv
// Raster-to-block reorder: writes one 8-line strip linearly into a single-port SRAM,
// then reads it back in 8x8 block order through a 2-entry output FIFO.
module strip_block_reorder #(
  parameter int IMG_WIDTH   = 640,
  parameter int WORDSIZE    = 16,
  parameter int ADDRESSSIZE = 15
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iPixValid,
  input  logic [WORDSIZE-1:0]    iPixData,
  output logic                   oPixReady,
  output logic                   oBlkValid,
  output logic [WORDSIZE-1:0]    oBlkData,
  output logic                   oBlkLast,
  output logic                   oStripLast,
  input  logic                   iBlkReady,
  output logic                   oNWRT,
  output logic                   oNCE,
  output logic [WORDSIZE-1:0]    oDIN,
  output logic [ADDRESSSIZE-5:0] oRA,
  output logic [3:0]             oCA,
  input  logic [WORDSIZE-1:0]    iDO
);

  localparam int StripPix = 8 * IMG_WIDTH;

  typedef enum logic {StFill, StDrain} state_e;

  state_e                 r_state;
  logic [ADDRESSSIZE-1:0] r_wr_cnt;
  logic [ADDRESSSIZE-1:0] r_blk_base;
  logic [ADDRESSSIZE-1:0] r_row_base;
  logic [2:0]             r_row;
  logic [2:0]             r_col;
  logic                   r_rd_done;
  logic                   r_inflight;
  logic                   r_if_blk_last;
  logic                   r_if_strip_last;
  logic [WORDSIZE-1:0]    r_fd [2];
  logic                   r_fb [2];
  logic                   r_fs [2];
  logic                   r_wp;
  logic                   r_rp;
  logic [1:0]             r_cnt;

  logic                   w_accept;
  logic                   w_issue;
  logic                   w_pop;
  logic                   w_blk_valid;
  logic [2:0]             w_occ;
  logic                   w_last_col;
  logic                   w_last_row;
  logic                   w_last_blk;
  logic [ADDRESSSIZE-1:0] w_rd_addr;
  logic [ADDRESSSIZE-1:0] w_addr;

  assign w_blk_valid = (r_cnt != 2'd0) && !iReset;
  assign w_pop       = w_blk_valid && iBlkReady;
  assign w_accept    = (r_state == StFill) && iPixValid && !iReset;
  assign w_occ       = {1'b0, r_cnt} + {2'b0, r_inflight};
  // Occupancy after this cycle's pop must leave room for the read issued now.
  assign w_issue     = (r_state == StDrain) && !r_rd_done && !iReset &&
                       (w_occ < (3'd2 + {2'b0, w_pop}));

  assign w_last_col  = (r_col == 3'd7);
  assign w_last_row  = (r_row == 3'd7);
  assign w_last_blk  = (r_blk_base == ADDRESSSIZE'(IMG_WIDTH - 8));
  assign w_rd_addr   = r_row_base + ADDRESSSIZE'(r_col);
  assign w_addr      = (r_state == StFill) ? r_wr_cnt : w_rd_addr;

  assign oPixReady  = (r_state == StFill) && !iReset;
  assign oBlkValid  = w_blk_valid;
  assign oBlkData   = r_fd[r_rp];
  assign oBlkLast   = w_blk_valid && r_fb[r_rp];
  assign oStripLast = w_blk_valid && r_fs[r_rp];
  assign oNCE       = !(w_accept || w_issue);
  assign oNWRT      = !w_accept;
  assign oDIN       = iPixData;
  assign oRA        = w_addr[ADDRESSSIZE-1:4];
  assign oCA        = w_addr[3:0];

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state         <= StFill;
      r_wr_cnt        <= '0;
      r_blk_base      <= '0;
      r_row_base      <= '0;
      r_row           <= '0;
      r_col           <= '0;
      r_rd_done       <= 1'b0;
      r_inflight      <= 1'b0;
      r_if_blk_last   <= 1'b0;
      r_if_strip_last <= 1'b0;
      r_wp            <= 1'b0;
      r_rp            <= 1'b0;
      r_cnt           <= '0;
    end else begin
      if (w_accept) begin
        if (r_wr_cnt == ADDRESSSIZE'(StripPix - 1)) begin
          r_wr_cnt <= '0;
          r_state  <= StDrain;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end

      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_blk_last   <= w_last_col && w_last_row;
        r_if_strip_last <= w_last_col && w_last_row && w_last_blk;
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row <= '0;
            if (w_last_blk) begin
              r_rd_done <= 1'b1;
            end else begin
              r_blk_base <= r_blk_base + ADDRESSSIZE'(8);
              r_row_base <= r_blk_base + ADDRESSSIZE'(8);
            end
          end else begin
            r_row      <= r_row + 1'b1;
            r_row_base <= r_row_base + ADDRESSSIZE'(IMG_WIDTH);
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      // Read data from the previous cycle's issue lands in the FIFO now.
      if (r_inflight) begin
        r_fd[r_wp] <= iDO;
        r_fb[r_wp] <= r_if_blk_last;
        r_fs[r_wp] <= r_if_strip_last;
        r_wp       <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

      if (w_pop && r_fs[r_rp]) begin
        r_state    <= StFill;
        r_blk_base <= '0;
        r_row_base <= '0;
        r_row      <= '0;
        r_col      <= '0;
        r_rd_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_strip_block_reorder.sv
// Directed bench for strip_block_reorder at IMG_WIDTH=16 with a behavioural SRAM.
module tb_strip_block_reorder;

  localparam int W  = 16;
  localparam int NP = 8 * W;

  logic        clk = 1'b0;
  logic        iReset, iPixValid, iBlkReady;
  logic [15:0] iPixData;
  logic        oPixReady, oBlkValid, oBlkLast, oStripLast, oNWRT, oNCE;
  logic [15:0] oBlkData, oDIN, iDO;
  logic [10:0] oRA;
  logic [3:0]  oCA;

  strip_block_reorder #(.IMG_WIDTH(W), .WORDSIZE(16), .ADDRESSSIZE(15)) dut (
    .iClk(clk), .iReset(iReset), .iPixValid(iPixValid), .iPixData(iPixData),
    .oPixReady(oPixReady), .oBlkValid(oBlkValid), .oBlkData(oBlkData),
    .oBlkLast(oBlkLast), .oStripLast(oStripLast), .iBlkReady(iBlkReady),
    .oNWRT(oNWRT), .oNCE(oNCE), .oDIN(oDIN), .oRA(oRA), .oCA(oCA), .iDO(iDO)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, write on the same edge.
  logic [15:0] mem [32768];
  always @(posedge clk) begin
    if (!oNCE && !oNWRT) mem[{oRA, oCA}] <= oDIN;
    if (!oNCE && oNWRT) iDO <= mem[{oRA, oCA}];
  end

  typedef struct {int cyc; logic [15:0] d; logic bl; logic sl;} pop_t;
  typedef struct {int cyc; logic [14:0] a; logic [15:0] d;} wr_t;
  pop_t pop_q[$];
  wr_t  wr_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_rd = 0, n_pop = 0, max_out = 0, stall_err = 0;
  logic have_stall = 1'b0;
  logic [15:0] s_d;
  logic s_bl, s_sl;

  always @(negedge clk) begin
    if (iReset) begin
      n_rd = 0; n_pop = 0; have_stall = 1'b0;
    end else begin
      if (!oNCE && !oNWRT) wr_q.push_back('{cyc, {oRA, oCA}, oDIN});
      if (!oNCE && oNWRT) n_rd++;
      if (have_stall && !(oBlkValid === 1'b1 && oBlkData === s_d && oBlkLast === s_bl &&
                          oStripLast === s_sl)) stall_err++;
      have_stall = oBlkValid && !iBlkReady;
      s_d = oBlkData; s_bl = oBlkLast; s_sl = oStripLast;
      if (oBlkValid && iBlkReady) begin
        pop_q.push_back('{cyc, oBlkData, oBlkLast, oStripLast});
        n_pop++;
      end
      if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
    end
  end

  int n_total = 0, n_pass = 0;
  int gap_bad = 0;
  logic pr_in_drain;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_val(input int k);
    return ((k % 64) / 8) * W + 8 * (k / 64) + (k % 8);
  endfunction

  task automatic send_strip(input int base, input bit gaps, input logic keep_valid);
    for (int i = 0; i < NP; i++) begin
      if (gaps && (i % 7 == 3)) begin
        iPixValid = 1'b0;
        @(negedge clk);
        if (oNCE !== 1'b1) gap_bad++;
        @(posedge clk); #1;
      end
      iPixValid = 1'b1;
      iPixData  = 16'(base + i);
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (oPixReady === 1'b1) break;
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    iPixValid = keep_valid;
    iPixData  = 16'hdead;
  endtask

  task automatic drain(input int n, input bit rnd);
    for (int t = 0; t < 3000; t++) begin
      iBlkReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (t == 20) pr_in_drain = oPixReady;
      @(posedge clk); #1;
      if (pop_q.size() >= n) break;
    end
    iBlkReady = 1'b0;
  endtask

  task automatic check_order(input string tag, input int base);
    int nbad = 0;
    check({tag, "_count"}, pop_q.size(), NP);
    foreach (pop_q[k]) if (pop_q[k].d !== 16'(base + exp_val(k))) nbad++;
    check({tag, "_order_errs"}, nbad, 0);
  endtask

  task automatic check_writes(input string tag, input int base);
    int nbad = 0;
    check({tag, "_wr_count"}, wr_q.size(), NP);
    foreach (wr_q[k]) if (wr_q[k].a !== 15'(k) || wr_q[k].d !== 16'(base + k)) nbad++;
    check({tag, "_wr_errs"}, nbad, 0);
  endtask

  initial begin
    int nbad;
    iReset = 1'b1; iPixValid = 1'b0; iPixData = '0; iBlkReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pix_ready", oPixReady, 0);
    check("rst_blk_valid", oBlkValid, 0);
    check("rst_nce", oNCE, 1);
    check("rst_nwrt", oNWRT, 1);
    check("rst_lasts", {oBlkLast, oStripLast}, 0);
    @(posedge clk); #1;
    iReset = 1'b0;

    // Strip 0, continuous valid, pixels still offered during drain.
    pop_q.delete(); wr_q.delete();
    send_strip(0, 1'b0, 1'b1);
    drain(NP, 1'b0);
    check("ready_after_drain", oPixReady, 1);
    iPixValid = 1'b0;
    check("pix_ready_in_drain", pr_in_drain, 0);
    check_writes("s0", 0);
    check_order("s0", 0);
    nbad = 0;
    foreach (pop_q[k]) begin
      if (pop_q[k].bl !== (k % 64 == 63)) nbad++;
      if (pop_q[k].sl !== (k == NP - 1)) nbad++;
    end
    check("last_flag_errs", nbad, 0);
    check("first_valid_latency", pop_q[0].cyc - wr_q[NP-1].cyc, 3);
    check("consecutive_pops", pop_q[NP-1].cyc - pop_q[0].cyc, NP - 1);

    // Gaps in valid during fill, random back-pressure during drain.
    pop_q.delete(); wr_q.delete();
    send_strip(500, 1'b1, 1'b0);
    drain(NP, 1'b1);
    check("gap_nce_errs", gap_bad, 0);
    check_writes("gap", 500);
    check_order("rand", 500);
    check("stall_stability_errs", stall_err, 0);
    check("max_outstanding_le2", max_out <= 2, 1);

    // Reset after 40 outputs of a drain.
    pop_q.delete(); wr_q.delete();
    send_strip(0, 1'b0, 1'b0);
    drain(40, 1'b0);
    iReset = 1'b1;
    @(negedge clk);
    check("mid_rst_nce", oNCE, 1);
    check("mid_rst_pops", pop_q.size(), 40);
    @(posedge clk); #1;
    iReset = 1'b0;
    @(negedge clk);
    check("post_rst_blk_valid", oBlkValid, 0);
    check("post_rst_fill", oPixReady, 1);
    @(posedge clk); #1;
    pop_q.delete(); wr_q.delete();
    send_strip(1000, 1'b0, 1'b0);
    drain(NP, 1'b0);
    check_order("fresh", 1000);
    check("fresh_first", pop_q[0].d, 1000);
    check("fresh_second", pop_q[1].d, 1001);

    // Back-to-back strips without reset.
    for (int s = 0; s < 2; s++) begin
      pop_q.delete(); wr_q.delete();
      send_strip(s * 128, 1'b0, 1'b0);
      drain(NP, 1'b0);
      check_order(s == 0 ? "b2b0" : "b2b1", s * 128);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/strip_block_reorder.md
# strip_block_reorder

Raster-to-block reorder front end for the JPEG encoder's working SRAM (32768×16, single port, 1-cycle registered read). Accepts one raster strip of 8 image lines over a valid/ready pixel stream, writes it linearly into the SRAM, then reads it back in 8×8 block order to the DCT-side consumer over a second valid/ready stream. It drives the SRAM's NWRT/DIN/RA/CA/NCE ports directly and takes its DO.

## Interface
- IMG_WIDTH, 640, pixels per line; a multiple of 8, and ≤ 4096 so that 8·IMG_WIDTH ≤ 32768.
- WORDSIZE, 16, pixel / SRAM word width.
- ADDRESSSIZE, 15, SRAM linear address width; {RA,CA} = address, RA = A[14:4], CA = A[3:0].

Ports:
- iClk  in  1  the single clock; all logic is on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iPixValid  in  1  raster pixel valid.
- iPixData  in  WORDSIZE  raster pixel.
- oPixReady  out  1  pixel accepted when iPixValid && oPixReady.
- oBlkValid  out  1  block-order sample valid.
- oBlkData  out  WORDSIZE  block-order sample.
- oBlkLast  out  1  marks sample 63 of each 8×8 block.
- oStripLast  out  1  marks the final sample of the strip.
- iBlkReady  in  1  sample consumed when oBlkValid && iBlkReady.
- oNWRT  out  1  SRAM write enable (active low).
- oNCE  out  1  SRAM chip enable (active low).
- oDIN  out  WORDSIZE  SRAM write data.
- oRA  out  11  SRAM row address.
- oCA  out  4  SRAM column address.
- iDO  in  WORDSIZE  SRAM read data.

## Operation
- Two states: FILL and DRAIN. Reset enters FILL.
- Reset values: wr_cnt = 0, block/row/col read counters = 0, FIFO empty, in-flight flag = 0. Outputs during reset: oPixReady = 0, oBlkValid = 0, oBlkLast = 0, oStripLast = 0, oNCE = 1, oNWRT = 1.
- SRAM ports are combinational from registered state/counters plus the handshake. oDIN = iPixData at all times.
- Idle SRAM cycle: oNCE = 1, oNWRT = 1.
- **FILL**
  - oPixReady = 1.
  - On accept: oNCE = 0, oNWRT = 0, address = wr_cnt; wr_cnt++.
  - After accepting pixel 8·IMG_WIDTH−1, go to DRAIN and clear wr_cnt.
- **DRAIN**
  - oPixReady = 0.
  - Read order: for block b = 0..IMG_WIDTH/8−1, row r = 0..7, col c = 0..7, address = r·IMG_WIDTH + 8b + c. Generate addresses with incremental counters; no multiplier.
  - Read issue: oNCE = 0, oNWRT = 1. Allowed when reads remain and (fifo_count + inflight − pop) < 2.
  - A read issued in cycle t presents iDO in cycle t+1. It is pushed into a 2-entry output FIFO at the end of t+1, tagged with its Last flags.
  - oBlkValid = FIFO non-empty; oBlkData, oBlkLast and oStripLast come from the FIFO head.
  - Go to FILL in the cycle after the pop of the oStripLast sample; clear all read counters.
- No read and write ever occur in the same cycle; the SRAM port is exclusive per state.
- Pixels offered during DRAIN are not accepted, and back-pressure holds indefinitely.
- Synchronous reset mid-FILL or mid-DRAIN discards the strip: FIFO is flushed, the state returns to FILL, and no SRAM access occurs in the reset cycle.

## Timing
- Write latency: a pixel accepted in cycle t is written at the edge ending cycle t.
- Drain latency: with DRAIN entered at cycle t and iBlkReady held at 1, the first oBlkValid appears in cycle t+2. Output then runs at 1 sample/cycle; the last sample is in cycle t+1+8·IMG_WIDTH, and FILL resumes at cycle t+2+8·IMG_WIDTH.
- Under back-pressure, oBlkData, oBlkLast and oStripLast hold stable while oBlkValid && !iBlkReady. No sample is lost or duplicated, and FIFO overflow is impossible by the issue rule.
- Fill throughput is 1 pixel/cycle.

## Test plan
- IMG_WIDTH=16, with pixel value = raster index 0..127 streamed with continuous valid:
  - 128 writes to addresses 0..127 with oNWRT = 0.
  - Outputs are 0–7, 16–23, …, 112–119, then 8–15, 24–31, …, 120–127.
  - oBlkLast on the 64th and 128th samples; oStripLast on the 128th only.
- Same stimulus with iBlkReady = 1: first oBlkValid 2 cycles after DRAIN entry, 128 consecutive valid cycles, oPixReady = 1 again in the cycle after the last pop.
- Random iBlkReady (about 50%): same 128-value sequence, data stable while stalled, never more than 2 reads outstanding beyond consumption.
- Pixels presented during DRAIN: oPixReady = 0, no SRAM write. Gaps in iPixValid during FILL: oNCE = 1 in gap cycles, and addresses stay contiguous.
- iReset asserted after 40 outputs of a drain: next cycle oBlkValid = 0 and the state is FILL. A fresh strip with values 1000+index then drains correctly, starting 1000, 1001, ….
- Two back-to-back strips (values k·128+index): the second strip's output order matches the first with the offset applied, and no first-strip residue appears.
